// File: rtl/reg_file_fwd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_fwd_pkg
// Description : Shared definitions for the register-file read bypass stage:
//               default geometry, the hardwired-zero register index and the
//               per-read-port state record {cap_reg, byp_valid, byp_data}.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_file_fwd_pkg;

  localparam int unsigned DEF_WIDTH       = 32;
  localparam int unsigned DEF_NUMREGS     = 32;
  localparam int unsigned DEF_LOG2NUMREGS = 5;

  // Architectural register that always reads as zero.
  localparam int unsigned REG_ZERO = 0;

  // Per-read-port state at the default geometry.
  typedef struct packed {
    logic [DEF_LOG2NUMREGS-1:0] cap_reg;
    logic                       byp_valid;
    logic [DEF_WIDTH-1:0]       byp_data;
  } port_state_t;

endpackage
`default_nettype wire

// File: rtl/reg_file_fwd_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_fwd_if
// Description : Bundle of the two read ports (A, B) and the writeback port of
//               the register-file bypass stage.
//               master : drives read indices/enables, raw RAM data, writeback
//               slave  : the bypass stage; returns corrected operands + hits
// Ports       : a_* / b_* read ports, c_* writeback port (see signals below)
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_fwd_if
  import reg_file_fwd_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned LOG2NUMREGS = DEF_LOG2NUMREGS
);

  // Read port A
  logic [LOG2NUMREGS-1:0] a_reg;
  logic                   a_en;
  logic [WIDTH-1:0]       a_rfdata;
  logic [WIDTH-1:0]       a_readdataout;
  logic                   a_fwd_hit;

  // Read port B
  logic [LOG2NUMREGS-1:0] b_reg;
  logic                   b_en;
  logic [WIDTH-1:0]       b_rfdata;
  logic [WIDTH-1:0]       b_readdataout;
  logic                   b_fwd_hit;

  // Writeback port
  logic [LOG2NUMREGS-1:0] c_reg;
  logic [WIDTH-1:0]       c_writedatain;
  logic                   c_we;

  modport master (
    output a_reg, a_en, a_rfdata,
    output b_reg, b_en, b_rfdata,
    output c_reg, c_writedatain, c_we,
    input  a_readdataout, a_fwd_hit,
    input  b_readdataout, b_fwd_hit
  );

  modport slave (
    input  a_reg, a_en, a_rfdata,
    input  b_reg, b_en, b_rfdata,
    input  c_reg, c_writedatain, c_we,
    output a_readdataout, a_fwd_hit,
    output b_readdataout, b_fwd_hit
  );

endinterface
`default_nettype wire

// File: rtl/reg_file_fwd_port.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_fwd_port
// Description : One read port of the bypass stage. Remembers which register
//               the RAM captured, tracks writeback writes to it (including the
//               write on the capture edge that the RAM misses) and muxes the
//               newest written value over the raw RAM data.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               x_reg/x_en        - read index and capture enable (0 = stall)
//               x_rfdata          - raw RAM read data
//               c_reg/c_writedatain/c_we - writeback port
//               x_readdataout     - corrected operand
//               x_fwd_hit         - operand sourced from the bypass register
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_fwd_port
  import reg_file_fwd_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned NUMREGS     = DEF_NUMREGS,
  parameter int unsigned LOG2NUMREGS = DEF_LOG2NUMREGS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LOG2NUMREGS-1:0] x_reg,
  input  logic                   x_en,
  input  logic [WIDTH-1:0]       x_rfdata,
  input  logic [LOG2NUMREGS-1:0] c_reg,
  input  logic [WIDTH-1:0]       c_writedatain,
  input  logic                   c_we,
  output logic [WIDTH-1:0]       x_readdataout,
  output logic                   x_fwd_hit
);

  localparam logic [LOG2NUMREGS-1:0] ZERO_IDX = LOG2NUMREGS'(REG_ZERO);

  typedef struct packed {
    logic [LOG2NUMREGS-1:0] cap_reg;
    logic                   byp_valid;
    logic [WIDTH-1:0]       byp_data;
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [LOG2NUMREGS-1:0] match_reg;
  logic                   wr_hit;
  logic                   cap_is_zero;

  always_comb begin
    // On a capture edge the write must be compared against the index being
    // captured now, since the RAM returns the pre-write value for it.
    match_reg = x_en ? x_reg : state_q.cap_reg;
    wr_hit    = c_we && (c_reg == match_reg) && (c_reg != ZERO_IDX)
                && (32'(c_reg) < NUMREGS);

    state_d = state_q;
    if (x_en) begin
      state_d.cap_reg   = x_reg;
      state_d.byp_valid = wr_hit;
      state_d.byp_data  = c_writedatain;
    end else if (wr_hit) begin
      // RAM output is frozen during a stall; the latest write wins.
      state_d.byp_valid = 1'b1;
      state_d.byp_data  = c_writedatain;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign cap_is_zero   = (state_q.cap_reg == ZERO_IDX);
  assign x_fwd_hit     = state_q.byp_valid && !cap_is_zero;
  assign x_readdataout = cap_is_zero       ? '0 :
                         state_q.byp_valid ? state_q.byp_data :
                                             x_rfdata;

endmodule
`default_nettype wire

// File: rtl/reg_file_fwd.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_fwd
// Description : Read-side bypass stage between the dual-read register file
//               and execute. Two independent port instances (A, B) share the
//               writeback port, so both may bypass the same write.
// Ports       : clk   - single clock, rising edge
//               reset - synchronous active-high reset
//               bus   - reg_file_fwd_if slave (read ports A/B, writeback C)
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_fwd
  import reg_file_fwd_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned NUMREGS     = DEF_NUMREGS,
  parameter int unsigned LOG2NUMREGS = DEF_LOG2NUMREGS
) (
  input  logic          clk,
  input  logic          reset,
  reg_file_fwd_if.slave bus
);

  reg_file_fwd_port #(
    .WIDTH       (WIDTH),
    .NUMREGS     (NUMREGS),
    .LOG2NUMREGS (LOG2NUMREGS)
  ) u_port_a (
    .clk           (clk),
    .reset         (reset),
    .x_reg         (bus.a_reg),
    .x_en          (bus.a_en),
    .x_rfdata      (bus.a_rfdata),
    .c_reg         (bus.c_reg),
    .c_writedatain (bus.c_writedatain),
    .c_we          (bus.c_we),
    .x_readdataout (bus.a_readdataout),
    .x_fwd_hit     (bus.a_fwd_hit)
  );

  reg_file_fwd_port #(
    .WIDTH       (WIDTH),
    .NUMREGS     (NUMREGS),
    .LOG2NUMREGS (LOG2NUMREGS)
  ) u_port_b (
    .clk           (clk),
    .reset         (reset),
    .x_reg         (bus.b_reg),
    .x_en          (bus.b_en),
    .x_rfdata      (bus.b_rfdata),
    .c_reg         (bus.c_reg),
    .c_writedatain (bus.c_writedatain),
    .c_we          (bus.c_we),
    .x_readdataout (bus.b_readdataout),
    .x_fwd_hit     (bus.b_fwd_hit)
  );

endmodule
`default_nettype wire

// File: tb/tb_reg_file_fwd.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_fwd
// Description : Testbench for reg_file_fwd. Models the register-file RAM
//               (registered read address, OLD_DATA on same-edge write, stale
//               output while stalled) to drive a/b_rfdata, and predicts each
//               operand as the current architectural value of the captured
//               register. Expected results are queued per cycle and checked
//               by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_fwd;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  reg_file_fwd_if #(.WIDTH(32), .LOG2NUMREGS(5)) bus ();

  reg_file_fwd #(.WIDTH(32), .NUMREGS(32), .LOG2NUMREGS(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] a_data;
    logic        a_hit;
    logic [31:0] b_data;
    logic        b_hit;
  } exp_t;

  exp_t exp_q[$];

  int vectors     = 0;
  int miscompares = 0;

  // RAM model and architectural tracking
  logic [31:0] ram [32];
  logic [4:0]  cap_a = '0, cap_b = '0;
  bit          wr_a = 1'b0, wr_b = 1'b0;

  // Value register r holds once this edge's write (if any) has landed.
  function automatic logic [31:0] arch_after(input logic [4:0] r, input bit we,
                                             input logic [4:0] cr, input logic [31:0] cd);
    if (r == 5'd0) return 32'd0;
    if (we && cr == r) return cd;
    return ram[r];
  endfunction

  task automatic step(input bit rst, input bit ea, input logic [4:0] ra,
                      input bit eb, input logic [4:0] rb,
                      input bit we, input logic [4:0] cr, input logic [31:0] cd);
    exp_t        e;
    logic [4:0]  na, nb;
    bit          ha, hb, nwa, nwb;
    @(negedge clk);
    reset            = rst;
    bus.a_en         = ea;
    bus.a_reg        = ra;
    bus.b_en         = eb;
    bus.b_reg        = rb;
    bus.c_we         = we;
    bus.c_reg        = cr;
    bus.c_writedatain = cd;

    na  = rst ? 5'd0 : (ea ? ra : cap_a);
    nb  = rst ? 5'd0 : (eb ? rb : cap_b);
    ha  = !rst && we && cr != 5'd0 && cr == na;
    hb  = !rst && we && cr != 5'd0 && cr == nb;
    nwa = rst ? 1'b0 : (ea ? ha : (wr_a | ha));
    nwb = rst ? 1'b0 : (eb ? hb : (wr_b | hb));

    e.a_data = arch_after(na, we, cr, cd);
    e.a_hit  = nwa && na != 5'd0;
    e.b_data = arch_after(nb, we, cr, cd);
    e.b_hit  = nwb && nb != 5'd0;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    // RAM: reads see the pre-write contents; output holds while not enabled.
    if (ea) bus.a_rfdata = ram[ra];
    if (eb) bus.b_rfdata = ram[rb];
    if (we) ram[cr] = cd;
    cap_a = na;  cap_b = nb;
    wr_a  = nwa; wr_b  = nwb;
  endtask

  // Monitor: one output set per clock edge, sampled after RAM data settles.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (bus.a_readdataout !== e.a_data) begin
          miscompares++;
          $display("FAIL a_data @%0t: got %h expected %h", $time, bus.a_readdataout, e.a_data);
        end
        vectors++;
        if (bus.a_fwd_hit !== e.a_hit) begin
          miscompares++;
          $display("FAIL a_hit @%0t: got %b expected %b", $time, bus.a_fwd_hit, e.a_hit);
        end
        vectors++;
        if (bus.b_readdataout !== e.b_data) begin
          miscompares++;
          $display("FAIL b_data @%0t: got %h expected %h", $time, bus.b_readdataout, e.b_data);
        end
        vectors++;
        if (bus.b_fwd_hit !== e.b_hit) begin
          miscompares++;
          $display("FAIL b_hit @%0t: got %b expected %b", $time, bus.b_fwd_hit, e.b_hit);
        end
      end
    end
  end

  initial begin
    bus.a_reg = '0; bus.a_en = 1'b0; bus.a_rfdata = '0;
    bus.b_reg = '0; bus.b_en = 1'b0; bus.b_rfdata = '0;
    bus.c_reg = '0; bus.c_we = 1'b0; bus.c_writedatain = '0;
    for (int i = 0; i < 32; i++) ram[i] = $urandom;
    ram[0] = 32'h0000_FFFF;
    ram[5] = 32'h0000_1111;

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 5, 1, 6, 1, 5, 32'hDEAD);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Plain capture of r5, then hold
    step(0, 1, 5, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // Capture on the same edge as a write to r5
    step(0, 1, 5, 0, 0, 1, 5, 32'h0000_ABCD);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // Stall on r7 with two writes, then capture r8 clean
    step(0, 1, 7, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 7, 32'h22);
    step(0, 0, 0, 0, 0, 1, 7, 32'h33);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 8, 0, 0, 0, 0, 0);
    // Register 0 on port B, with a write to r0
    step(0, 0, 0, 1, 0, 1, 0, 32'h1234);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // Both ports on r3, bypass one write, ignore a write to r4
    step(0, 1, 3, 1, 3, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 3, 32'h5A5A);
    step(0, 0, 0, 0, 0, 1, 4, 32'h7777);
    // Reset mid-stall discards bypass; recapture r9 reads RAM
    step(0, 1, 9, 1, 9, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 9, 32'h99);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 9, 1, 9, 0, 0, 0);

    // Random traffic on a small register window to make hits frequent
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 99) < 3),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)),
           32'($urandom));
    end

    #10;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
